// File: rtl/cpu_consts_pkg.sv
// Shared constants and types for the load/store stage.
//   mem_size_t  : access size encoding (B/H/W/D)
//   lsu_state_t : LSU control FSM states
//   dmem_req_t  : data-memory request payload (we, addr, be, wdata)
//   EXC_*       : RISC-V mcause codes raised by the LSU
package cpu_consts;

  localparam int unsigned DW = 64;
  localparam int unsigned BE_W = DW / 8;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [DW-1:0]   addr;
    logic [BE_W-1:0] be;
    logic [DW-1:0]   wdata;
  } dmem_req_t;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_low_mask(input mem_size_t s);
    case (s)
      MEM_B:   return 3'b000;
      MEM_H:   return 3'b001;
      MEM_W:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering for the LSU.
//   st_*  : byte-enable and store-data placement for an outgoing access
//   ld_*  : extraction, truncation and sign/zero extension of read data
module lsu_data_align
  import cpu_consts::*;
(
  input  logic [2:0]      st_off,
  input  mem_size_t       st_size,
  input  logic [DW-1:0]   st_wdata,
  output logic [BE_W-1:0] st_be,
  output logic [DW-1:0]   st_wdata_lane,
  input  logic [2:0]      ld_off,
  input  mem_size_t       ld_size,
  input  logic            ld_unsigned,
  input  logic [DW-1:0]   ld_rdata,
  output logic [DW-1:0]   ld_data
);

  logic [BE_W-1:0] size_be;
  logic [DW-1:0]   ld_shift;

  // Store side: size mask and data moved up to the addressed byte lane.
  always_comb begin
    case (st_size)
      MEM_B:   size_be = 8'h01;
      MEM_H:   size_be = 8'h03;
      MEM_W:   size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
    st_be         = size_be << st_off;
    st_wdata_lane = st_wdata << {st_off, 3'b000};
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    case (ld_size)
      MEM_B:   ld_data = {{56{~ld_unsigned & ld_shift[7]}},  ld_shift[7:0]};
      MEM_H:   ld_data = {{48{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      MEM_W:   ld_data = {{32{~ld_unsigned & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// RV64 load/store stage: one outstanding req/gnt/rvalid data-memory access,
// result returned to writeback over a valid/ready handshake.
// Ports:
//   clk_i, resetn_i            clock, synchronous active-low reset
//   ex_*                       request from execute (valid/ready)
//   dmem_*                     data-memory port (req/gnt, rvalid/rdata/err)
//   wb_*                       result to writeback (valid/ready)
// Build option: LSU_MISALIGN_TRAP_EN -- trap misaligned accesses instead of
// silently aligning the address down to the access size.
module lsu_stage
  import cpu_consts::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_we_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_unsigned_i,
  input  logic [RD_W-1:0] ex_rd_i,
  output logic            dmem_req_o,
  input  logic            dmem_gnt_i,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [7:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_err_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_rdata_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic            wb_we_o,
  output logic            wb_exc_o,
  output logic [3:0]      wb_exc_cause_o
);

  lsu_state_t      state_q, state_d;
  mem_size_t       ex_size;
  mem_size_t       size_q, size_d;
  logic [2:0]      off_q, off_d;
  logic            uns_q, uns_d;
  logic            we_q, we_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            ex_ready_q, ex_ready_d;
  logic            dmem_req_q, dmem_req_d;
  dmem_req_t       dmem_q, dmem_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_rdata_q, wb_rdata_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_exc_q, wb_exc_d;
  logic [3:0]      wb_cause_q, wb_cause_d;

  logic [2:0]      low_mask;
  logic [2:0]      issue_off;
  logic [7:0]      st_be;
  logic [XLEN-1:0] st_wdata_lane;
  logic [XLEN-1:0] ld_data;

  assign ex_size   = mem_size_t'(ex_size_i);
  assign low_mask  = size_low_mask(ex_size);
  // Dropping the sub-size offset bits aligns the access down; for an aligned
  // access this is a no-op.
  assign issue_off = ex_addr_i[2:0] & ~low_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(ex_addr_i[2:0] & low_mask);
`endif

  lsu_data_align u_align (
    .st_off        (issue_off),
    .st_size       (ex_size),
    .st_wdata      (ex_wdata_i),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .ld_off        (off_q),
    .ld_size       (size_q),
    .ld_unsigned   (uns_q),
    .ld_rdata      (dmem_rdata_i),
    .ld_data       (ld_data)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    uns_d      = uns_q;
    we_d       = we_q;
    rd_d       = rd_q;
    dmem_req_d = dmem_req_q;
    dmem_d     = dmem_q;
    wb_valid_d = wb_valid_q;
    wb_rdata_d = wb_rdata_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_exc_d   = wb_exc_q;
    wb_cause_d = wb_cause_q;

    case (state_q)
      LSU_IDLE: begin
        if (ex_valid_i) begin
          size_d = ex_size;
          off_d  = issue_off;
          uns_d  = ex_unsigned_i;
          we_d   = ex_we_i;
          rd_d   = ex_rd_i;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            // No bus traffic: report the trap directly.
            state_d    = LSU_RESP;
            wb_valid_d = 1'b1;
            wb_rdata_d = '0;
            wb_rd_d    = ex_rd_i;
            wb_we_d    = 1'b0;
            wb_exc_d   = 1'b1;
            wb_cause_d = ex_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          end else begin
`endif
            state_d      = LSU_REQ;
            dmem_req_d   = 1'b1;
            dmem_d.we    = ex_we_i;
            dmem_d.addr  = {ex_addr_i[XLEN-1:3], 3'b000};
            dmem_d.be    = st_be;
            dmem_d.wdata = st_wdata_lane;
`ifdef LSU_MISALIGN_TRAP_EN
          end
`endif
        end
      end

      LSU_REQ: begin
        if (dmem_gnt_i) begin
          state_d    = LSU_WAIT;
          dmem_req_d = 1'b0;
        end
      end

      LSU_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d    = LSU_RESP;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (dmem_err_i) begin
            wb_rdata_d = '0;
            wb_we_d    = 1'b0;
            wb_exc_d   = 1'b1;
            wb_cause_d = we_q ? EXC_ST_FAULT : EXC_LD_FAULT;
          end else begin
            wb_rdata_d = we_q ? '0 : ld_data;
            wb_we_d    = ~we_q;
            wb_exc_d   = 1'b0;
            wb_cause_d = 4'd0;
          end
        end
      end

      LSU_RESP: begin
        if (wb_ready_i) begin
          state_d    = LSU_IDLE;
          wb_valid_d = 1'b0;
        end
      end

      default: state_d = LSU_IDLE;
    endcase

    ex_ready_d = (state_d == LSU_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= LSU_IDLE;
      size_q     <= MEM_B;
      off_q      <= 3'd0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      ex_ready_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_exc_q   <= 1'b0;
      wb_cause_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      ex_ready_q <= ex_ready_d;
      dmem_req_q <= dmem_req_d;
      dmem_q     <= dmem_d;
      wb_valid_q <= wb_valid_d;
      wb_rdata_q <= wb_rdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_exc_q   <= wb_exc_d;
      wb_cause_q <= wb_cause_d;
    end
  end

  assign ex_ready_o     = ex_ready_q;
  assign dmem_req_o     = dmem_req_q;
  assign dmem_we_o      = dmem_q.we;
  assign dmem_addr_o    = dmem_q.addr;
  assign dmem_be_o      = dmem_q.be;
  assign dmem_wdata_o   = dmem_q.wdata;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rdata_o     = wb_rdata_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_we_o        = wb_we_q;
  assign wb_exc_o       = wb_exc_q;
  assign wb_exc_cause_o = wb_cause_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: expected writeback results are queued
// when a request is issued and compared when wb_valid_o is presented.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic        ex_we;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic        dmem_req;
  logic        dmem_gnt;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        dmem_err;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_rdata;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        wb_exc;
  logic [3:0]  wb_cause;

  typedef struct packed {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .ex_addr_i      (ex_addr),
    .ex_wdata_i     (ex_wdata),
    .ex_we_i        (ex_we),
    .ex_size_i      (ex_size),
    .ex_unsigned_i  (ex_unsigned),
    .ex_rd_i        (ex_rd),
    .dmem_req_o     (dmem_req),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_be_o      (dmem_be),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_err_i     (dmem_err),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_rdata_o     (wb_rdata),
    .wb_rd_o        (wb_rd),
    .wb_we_o        (wb_we),
    .wb_exc_o       (wb_exc),
    .wb_exc_cause_o (wb_cause)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference load extraction: shift lane down, keep size bytes, extend.
  function automatic logic [63:0] ld_model(input logic [63:0] rdata, input int off,
                                           input int size, input logic uns);
    logic [63:0] v;
    logic [63:0] r;
    int          nbits;
    v     = rdata >> (8 * off);
    nbits = 8 * (1 << size);
    r     = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < nbits) r[i] = v[i];
      else if (size != 3 && !uns) r[i] = v[nbits-1];
    end
    return r;
  endfunction

  task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata, input logic we,
                         input int size, input logic uns, input logic [4:0] rd,
                         input logic [63:0] rdata, input logic err, input int gnt_dly,
                         input int rdy_dly, input logic trap_exp);
    int          nb;
    int          off;
    logic [15:0] ones;
    logic [7:0]  exp_be;
    logic [63:0] exp_wd;
    logic [63:0] exp_addr;
    exp_t        e;
    exp_t        got;
    nb       = 1 << size;
    off      = int'(addr[2:0]) & ~(nb - 1);
    ones     = 16'hFFFF >> (16 - nb);
    exp_be   = 8'(ones << off);
    exp_wd   = wdata << (8 * off);
    exp_addr = {addr[63:3], 3'b000};

    e = '0;
    e.rd = rd;
    if (trap_exp) begin
      e.exc = 1'b1; e.cause = we ? 4'd6 : 4'd4;
    end else if (err) begin
      e.exc = 1'b1; e.cause = we ? 4'd7 : 4'd5;
    end else if (!we) begin
      e.we = 1'b1; e.rdata = ld_model(rdata, off, size, uns);
    end
    sb.push_back(e);

    @(negedge clk);
    check_eq("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_addr = addr; ex_wdata = wdata; ex_we = we;
    ex_size = 2'(size); ex_unsigned = uns; ex_rd = rd;
    @(negedge clk);
    // Scramble inputs to prove the stage latched them.
    ex_valid = 1'b0; ex_addr = ~addr; ex_wdata = ~wdata; ex_we = ~we; ex_rd = ~rd;

    if (!trap_exp) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq("dmem_req", 64'(dmem_req), 64'd1);
        check_eq("dmem_addr", dmem_addr, exp_addr);
        check_eq("dmem_be", 64'(dmem_be), 64'(exp_be));
        check_eq("dmem_wdata", dmem_wdata, exp_wd);
        check_eq("dmem_we", 64'(dmem_we), 64'(we));
        check_eq("ex_ready_busy", 64'(ex_ready), 64'd0);
        if (i == gnt_dly) dmem_gnt = 1'b1;
        @(negedge clk);
      end
      dmem_gnt = 1'b0;
      check_eq("req_after_gnt", 64'(dmem_req), 64'd0);
      dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_err = err;
      @(negedge clk);
      dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = {$urandom, $urandom};
    end else begin
      check_eq("trap_no_req", 64'(dmem_req), 64'd0);
    end

    check_eq("wb_valid_latency", 64'(wb_valid), 64'd1);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
      return;
    end
    got = sb.pop_front();
    for (int i = 0; i <= rdy_dly; i++) begin
      check_eq("wb_valid_hold", 64'(wb_valid), 64'd1);
      check_eq("wb_we", 64'(wb_we), 64'(got.we));
      check_eq("wb_exc", 64'(wb_exc), 64'(got.exc));
      if (got.exc) check_eq("wb_cause", 64'(wb_cause), 64'(got.cause));
      else check_eq("wb_rdata", wb_rdata, got.rdata);
      if (got.we) check_eq("wb_rd", 64'(wb_rd), 64'(got.rd));
      check_eq("ex_ready_resp", 64'(ex_ready), 64'd0);
      if (i == rdy_dly) wb_ready = 1'b1;
      @(negedge clk);
    end
    wb_ready = 1'b0;
    check_eq("wb_valid_drop", 64'(wb_valid), 64'd0);
    check_eq("ex_ready_back", 64'(ex_ready), 64'd1);
  endtask

  initial begin
    logic trap_lw;
    resetn = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_we = 1'b0;
    ex_size = 2'd0; ex_unsigned = 1'b0; ex_rd = '0; dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ex_ready", 64'(ex_ready), 64'd1);
    check_eq("rst_req", 64'(dmem_req), 64'd0);
    check_eq("rst_addr", dmem_addr, 64'd0);
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_wb_rdata", wb_rdata, 64'd0);
    resetn = 1'b1;

    // LB / LBU at 0x1003
    run_txn(64'h1003, 64'h0, 1'b0, 0, 1'b0, 5'd9, 64'h1122_3344_8566_7788, 1'b0, 0, 0, 1'b0);
    run_txn(64'h1003, 64'h0, 1'b0, 0, 1'b1, 5'd10, 64'h1122_3344_8566_7788, 1'b0, 0, 0, 1'b0);
    // SH at 0x2006, gnt late by 3 cycles, wb_ready low for 2
    run_txn(64'h2006, 64'hABCD, 1'b1, 1, 1'b0, 5'd3, 64'h0, 1'b0, 3, 2, 1'b0);
    // LW at 0x1002: trap or silently aligned depending on build
`ifdef LSU_MISALIGN_TRAP_EN
    trap_lw = 1'b1;
`else
    trap_lw = 1'b0;
`endif
    run_txn(64'h1002, 64'h0, 1'b0, 2, 1'b0, 5'd7, 64'h1122_3344_8566_7788, 1'b0, 0, 0, trap_lw);
    // LD bus error, SW bus error
    run_txn(64'h3000, 64'h0, 1'b0, 3, 1'b0, 5'd4, 64'hDEAD_BEEF_0000_1111, 1'b1, 0, 0, 1'b0);
    run_txn(64'h4004, 64'h1234_5678, 1'b1, 2, 1'b0, 5'd2, 64'h0, 1'b1, 1, 0, 1'b0);
    // LD ignores unsigned; LHU upper lane
    run_txn(64'h5000, 64'h0, 1'b0, 3, 1'b1, 5'd31, 64'h8000_0000_0000_0001, 1'b0, 0, 1, 1'b0);
    run_txn(64'h5006, 64'h0, 1'b0, 1, 1'b1, 5'd1, 64'hF00D_0000_0000_0000, 1'b0, 0, 0, 1'b0);

    // Random naturally aligned traffic
    for (int k = 0; k < 10; k++) begin
      int          sz;
      logic [63:0] a;
      sz = $urandom_range(0, 3);
      a  = {$urandom, $urandom};
      a[2:0] = 3'($urandom_range(0, 7) & ~((1 << sz) - 1));
      run_txn(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b0,
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    // Reset while waiting for rvalid; stray rvalid afterwards must be ignored
    @(negedge clk);
    ex_valid = 1'b1; ex_addr = 64'h6000; ex_we = 1'b0; ex_size = 2'd3; ex_rd = 5'd5;
    @(negedge clk);
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_eq("rstw_ex_ready", 64'(ex_ready), 64'd1);
    check_eq("rstw_req", 64'(dmem_req), 64'd0);
    check_eq("rstw_wb_valid", 64'(wb_valid), 64'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 64'h55;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stray_rvalid", 64'(wb_valid), 64'd0);
      @(negedge clk);
    end
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
